uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit frame serializer; consumes the parity bit produced by the TX parity generator.
//  - Accepts a byte on tx_start and issues load_data to the parity generator.
//  - Shifts out start, data (LSB first), optional parity and stop bits on tx, paced by baud_tick.
//  - Sits between the TX host interface and the serial pin.
// PARAMETERS
//  DATA_BITS      8   data bits per frame
//  TICKS_PER_BIT  16  baud_tick pulses per serial bit (oversample factor, >=2)
//  STOP_BITS      1   number of stop bits (1 or 2)
// PORTS
//  clk         in   1          system clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  baud_tick   in   1          one-cycle pulse at TICKS_PER_BIT x baud rate
//  tx_start    in   1          request to send tx_data; honoured only when idle
//  tx_data     in   DATA_BITS  byte to send; also drives the parity generator input
//  parity_bit  in   1          even-parity bit (XOR of tx_data) from the parity generator
//  load_data   out  1          enable to the parity generator
//  tx          out  1          serial line, idle high
//  tx_busy     out  1          frame in progress
//  tx_done     out  1          one-cycle pulse at end of frame
// BEHAVIOUR
//  - Reset (async, rst_n low): state=IDLE, tx=1, tx_busy=0, tx_done=0, tick/bit counters=0, shift reg=0.
//  - Reset mid-frame: tx returns high immediately; the frame is abandoned with no tx_done.
//  - load_data is combinational: tx_start & (state==IDLE).
//  - In the load_data cycle:
//    - tx_data is captured into the shift register.
//    - parity_bit is captured into the parity register.
//  - Next cycle: state=START, tx=0, tx_busy=1.
//  - tx_start while busy is ignored; no queuing, and load_data stays 0.
//  - Each bit period = TICKS_PER_BIT baud_tick pulses; the tick counter advances only on baud_tick.
//  - States and transitions (each leaves when its bit period ends):
//    - IDLE -> START on accept.
//    - START -> DATA.
//    - DATA: shift right after each bit; after DATA_BITS bits -> PARITY, or -> STOP without the parity feature.
//    - PARITY -> STOP.
//    - STOP: lasts STOP_BITS periods -> IDLE.
//  - tx is registered; it changes only on state or bit transitions.
//  - tx_done pulses for 1 cycle, coincident with the STOP->IDLE transition.
//  - tx_busy drops in that same cycle.
//  - tx_start in the tx_done cycle is accepted (back-to-back frames, no idle gap).
//  - Frame length in baud_ticks: (1+DATA_BITS+P+STOP_BITS)*TICKS_PER_BIT, P=1 with the parity feature else 0.
//  - baud_tick arriving in the accept cycle is not counted toward the START period.
// CONFIGURATION
//  UART_TX_PARITY_EN
//  - defined: PARITY state sends the captured parity_bit after the data bits (8E1 by default).
//  - undefined: PARITY state is never entered; parity_bit is ignored; load_data is still driven (8N1).
// STRUCTURE
//  - Package uart_tx_pkg holds:
//    - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP;
//    - LINE_IDLE=1'b1 and START_LVL=1'b0.
//  - One sub-module, uart_tx_bit_timer:
//    - counts baud_tick pulses modulo TICKS_PER_BIT;
//    - outputs bit_end when the count reaches TICKS_PER_BIT-1 on a baud_tick;
//    - cleared by the FSM on accept.
//  - Top level: FSM, shift register, bit counter and parity register.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles, then release.
//     -> tx=1, tx_busy=0, tx_done=0 throughout; load_data=0 while tx_start=0.
//  2. Send 8'h5E with parity_bit=1 (parity enabled), baud_tick every cycle.
//     -> bits on tx, each 16 cycles wide: 0 | 0,1,1,1,1,0,1,0 | 1 | 1.
//     -> tx_done pulses 176 cycles after the first START cycle.
//  3. Send 8'h5F with parity_bit=0, parity disabled.
//     -> 10-bit frame 0 | 1,1,1,1,1,0,1,0 | 1 with no parity slot; tx_done after 160 cycles.
//  4. Assert tx_start with 8'hA5 mid-frame of 8'h5E.
//     -> ignored; load_data=0; the 8'h5E frame completes unchanged.
//  5. Hold tx_start high with 8'h3C through tx_done.
//     -> the second frame's START bit begins on the next cycle with no idle high gap.
//  6. Pull rst_n low during DATA bit 3.
//     -> tx=1 asynchronously, tx_busy=0, no tx_done.
//     -> after release, a new 8'h01 frame sends correctly.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared encodings for the UART transmit serializer: FSM states and line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Host-side handshake and serial line of the UART transmit serializer.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 parity_bit;
  logic                 load_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start, tx_data, parity_bit,
    input  load_data, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, parity_bit,
    output load_data, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx_serializer_bit_timer.sv
// Counts baud_tick pulses modulo TICKS_PER_BIT and flags the last tick of each serial bit.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_baud_tick,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

  logic [CW-1:0] r_tick_cnt;
  logic          w_last;

  assign w_last    = (r_tick_cnt == CW'(TICKS_PER_BIT - 1));
  assign o_bit_end = i_baud_tick & w_last;

  // Clear wins over a coincident tick so the accept cycle never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (i_clr) begin
      r_tick_cnt <= '0;
    end else if (i_baud_tick) begin
      r_tick_cnt <= w_last ? '0 : r_tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, LSB-first data, optional parity, stop bits on a registered tx.
// Parity slot is built only when UART_TX_PARITY_EN is defined (8E1); otherwise frames are 8N1.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  uart_tx_serializer_if.slave   bus
);

  localparam int BCW = $clog2(DATA_BITS) + 1;

  state_e               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BCW-1:0]       r_bit_cnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic                 w_last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`else
  logic                 w_unused_parity;
  assign w_unused_parity = bus.parity_bit;
`endif

  assign w_accept    = bus.tx_start & (r_state == ST_IDLE);
  assign w_shift_nxt = r_shift >> 1;
  assign w_last_data = (r_bit_cnt == BCW'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BCW'(STOP_BITS - 1));

  assign bus.load_data = w_accept;
  assign bus.tx        = r_tx;
  assign bus.tx_busy   = r_busy;
  assign bus.tx_done   = r_done;

  uart_tx_bit_timer #(
    .TICKS_PER_BIT (TICKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_baud_tick (baud_tick),
    .i_clr       (w_accept),
    .o_bit_end   (w_bit_end)
  );

  // r_bit_cnt indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_START;
            r_shift   <= bus.tx_data;
            r_bit_cnt <= '0;
            r_tx      <= START_LVL;
            r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= bus.parity_bit;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= w_shift_nxt;
            if (w_last_data) begin
              r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= ST_PARITY;
              r_tx      <= r_parity;
`else
              r_state   <= ST_STOP;
              r_tx      <= LINE_IDLE;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= w_shift_nxt[0];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_state   <= ST_IDLE;
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
